// File: rtl/ysyx_23060072_mem_arbiter.sv
// ysyx_23060072_mem_arbiter: arbitrates IF reads and LSU loads/stores onto one memory port (ports: if_req/if_rsp fetch side, lsu_req/lsu_rsp load-store side, mem_req/mem_rsp downstream, busy)
module ysyx_23060072_mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_req_ready,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1) < 2 ? 2 : $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state;
  logic [SW-1:0] lsu_streak;
  logic owner_if, drop_flag, if_elig, lsu_win, if_win, drop_now;
  always_comb begin
    if_elig = if_req_valid && !if_flush;
    lsu_win = !rst && state == IDLE && lsu_req_valid && !(if_elig && lsu_streak == SW'(STARVE_LIMIT));
    if_win = !rst && state == IDLE && if_elig && !lsu_win;
    drop_now = drop_flag || if_flush;
  end
  assign if_req_ready = if_win;
  assign lsu_req_ready = lsu_win;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lsu_streak <= '0;
      owner_if <= 1'b0;
      drop_flag <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wen <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_rdata <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_rdata <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_streak <= (!if_req_valid || if_win) ? '0 :
                    (lsu_win && lsu_streak != SW'(STARVE_LIMIT)) ? lsu_streak + 1'b1 : lsu_streak;
      if (state != IDLE && owner_if && if_flush) drop_flag <= 1'b1;
      case (state)
        IDLE: if (if_win || lsu_win) begin
          state <= REQ;
          owner_if <= if_win;
          mem_req_valid <= 1'b1;
          mem_req_addr <= if_win ? if_req_addr : lsu_req_addr;
          mem_req_wen <= !if_win && lsu_req_wen;
          mem_req_wdata <= if_win ? '0 : lsu_req_wdata;
          mem_req_wstrb <= if_win ? '0 : lsu_req_wstrb;
        end
        REQ: if (mem_req_ready) begin
          state <= RSP;
          mem_req_valid <= 1'b0;
        end
        RSP: if (mem_rsp_valid) begin
          state <= IDLE;
          drop_flag <= 1'b0;
          if (owner_if && !drop_now) begin
            if_rsp_valid <= 1'b1;
            if_rsp_rdata <= mem_rsp_rdata;
          end
          if (!owner_if) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_rdata <= mem_rsp_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// tb_ysyx_23060072_mem_arbiter: vector table, memory model and response scoreboard for the memory arbiter
module tb_ysyx_23060072_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req_valid = 0, if_flush = 0, lsu_req_valid = 0, lsu_req_wen = 0;
  logic [31:0] if_req_addr = 0, lsu_req_addr = 0, lsu_req_wdata = 0;
  logic [3:0] lsu_req_wstrb = 0;
  logic mem_req_ready = 1, mem_rsp_valid = 0;
  logic [31:0] mem_rsp_rdata = 0;
  logic if_req_ready, if_rsp_valid, lsu_req_ready, lsu_rsp_valid, mem_req_valid, mem_req_wen, busy;
  logic [31:0] if_rsp_rdata, lsu_rsp_rdata, mem_req_addr, mem_req_wdata;
  logic [3:0] mem_req_wstrb;
  always #5 clk = ~clk;
  ysyx_23060072_mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
  );
  typedef struct packed {
    logic is_if;
    logic [31:0] addr;
    logic wen;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic drop;
  } txn_t;
  typedef struct packed {
    logic ifv;
    logic fl;
    logic lv;
    logic [31:0] la;
    logic wen;
    logic [31:0] wd;
    logic [3:0] ws;
    logic eif;
    logic elsu;
  } vec_t;
  txn_t sb[$];
  txn_t exp_t;
  logic exp_v = 0, pend = 0;
  logic grant_log[$];
  logic [31:0] pend_addr = 0;
  int checks = 0, errors = 0;
  int stall = 0, rsp_delay = 0, cnt = 0, hs_cnt = 0, if_pulses = 0, lsu_pulses = 0;
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a == 32'h8000_0000 ? 32'h0000_0013 : a ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    if_req_valid = 0;
    if_flush = 0;
    lsu_req_valid = 0;
    lsu_req_wen = 0;
    lsu_req_wdata = 0;
    lsu_req_wstrb = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() > 0 || exp_v || pend) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timed out, busy %b pending %0d", busy, sb.size());
    end
    tick();
  endtask
  // memory model and response scoreboard: sample at negedge, drive memory inputs just after posedge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_v) begin
        check("rsp_if_valid", if_rsp_valid, exp_t.is_if);
        check("rsp_lsu_valid", lsu_rsp_valid, !exp_t.is_if);
        if (!exp_t.wen) check("rsp_rdata", exp_t.is_if ? if_rsp_rdata : lsu_rsp_rdata, memfn(exp_t.addr));
      end else check("rsp_quiet", {if_rsp_valid, lsu_rsp_valid}, 0);
      exp_v = 0;
      if_pulses += if_rsp_valid;
      lsu_pulses += lsu_rsp_valid;
      check("ready_excl", if_req_ready && lsu_req_ready, 0);
      if (rst) sb.delete();
      else begin
        if (sb.size() > 0 && sb[0].is_if && if_flush) sb[0].drop = 1;
        if (mem_rsp_valid && sb.size() > 0) begin
          exp_t = sb.pop_front();
          exp_v = !exp_t.drop;
        end
        if (mem_req_valid && mem_req_ready) begin
          hs_cnt++;
          pend = 1;
          cnt = rsp_delay;
          pend_addr = mem_req_addr;
          if (sb.size() > 0) begin
            check("mem_addr", mem_req_addr, sb[0].addr);
            check("mem_wen", mem_req_wen, sb[0].wen);
            check("mem_wstrb", mem_req_wstrb, sb[0].wstrb);
            if (sb[0].wen) check("mem_wdata", mem_req_wdata, sb[0].wdata);
          end else check("hs_unexpected", mem_req_valid, 0);
        end else if (mem_req_valid && stall > 0) stall--;
        if (if_req_ready) begin
          sb.push_back('{1'b1, if_req_addr, 1'b0, 32'h0, 4'h0, 1'b0});
          grant_log.push_back(1'b1);
        end
        if (lsu_req_ready) begin
          sb.push_back('{1'b0, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb, 1'b0});
          grant_log.push_back(1'b0);
        end
      end
      @(posedge clk);
      #1;
      mem_req_ready = (stall == 0);
      mem_rsp_valid = 0;
      if (pend) begin
        if (cnt == 0) begin
          mem_rsp_valid = 1;
          mem_rsp_rdata = memfn(pend_addr);
          pend = 0;
        end else cnt--;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t vecs[8];
    logic [7:0] pat;
    int n, vcyc;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         4'h0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'h0,       4'h0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_2008, 1'b1, 32'h1111_2222, 4'h3, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0,       4'h0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,         4'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_3004, 1'b1, 32'hCAFE_F00D, 4'hC, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         4'h0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,         4'h0, 1'b1, 1'b0};
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_if_rdata", if_rsp_rdata, 0);
    check("rst_lsu_rdata", lsu_rsp_rdata, 0);
    check("rst_ready", {if_req_ready, lsu_req_ready}, 0);
    tick();
    rst = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if_req_valid = vecs[i].ifv;
      if_req_addr = 32'h8000_0100 + 32'(i * 4);
      if_flush = vecs[i].fl;
      lsu_req_valid = vecs[i].lv;
      lsu_req_addr = vecs[i].la;
      lsu_req_wen = vecs[i].wen;
      lsu_req_wdata = vecs[i].wd;
      lsu_req_wstrb = vecs[i].ws;
      @(negedge clk);
      check("vec_if_ready", if_req_ready, vecs[i].eif);
      check("vec_lsu_ready", lsu_req_ready, vecs[i].elsu);
      tick();
      idle_inputs();
      wait_idle();
    end
    if_req_valid = 1;
    if_req_addr = 32'h8000_0000;
    @(negedge clk);
    check("t_grant", if_req_ready, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t1_mem_valid", mem_req_valid, 1);
    check("t1_mem_addr", mem_req_addr, 32'h8000_0000);
    tick();
    @(negedge clk);
    check("t2_no_rsp", if_rsp_valid, 0);
    check("t2_busy", busy, 1);
    tick();
    @(negedge clk);
    check("t3_rsp", if_rsp_valid, 1);
    check("t3_rdata", if_rsp_rdata, 32'h0000_0013);
    wait_idle();
    grant_log.delete();
    if_req_valid = 1;
    if_req_addr = 32'h8000_0200;
    lsu_req_valid = 1;
    lsu_req_addr = 32'h0000_4000;
    n = 0;
    while (grant_log.size() < 8 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    tick();
    idle_inputs();
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL starve_timeout: grants %0d want 8", grant_log.size());
    end
    pat = 8'b1000_1000;
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check("grant_order", grant_log[i], pat[i]);
    wait_idle();
    stall = 4;
    tick();
    hs_cnt = 0;
    lsu_pulses = 0;
    lsu_req_valid = 1;
    lsu_req_addr = 32'h0000_1004;
    lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wstrb = 4'hF;
    @(negedge clk);
    check("st_grant", lsu_req_ready, 1);
    tick();
    idle_inputs();
    vcyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        vcyc++;
        check("st_addr", mem_req_addr, 32'h0000_1004);
        check("st_wdata", mem_req_wdata, 32'hDEAD_BEEF);
        check("st_wstrb", mem_req_wstrb, 4'hF);
        check("st_wen", mem_req_wen, 1);
      end
    end
    wait_idle();
    check("st_valid_cycles", vcyc, 5);
    check("st_handshakes", hs_cnt, 1);
    check("st_rsp_pulses", lsu_pulses, 1);
    rsp_delay = 2;
    if_pulses = 0;
    if_req_valid = 1;
    if_req_addr = 32'h8000_0300;
    @(negedge clk);
    check("fl_grant", if_req_ready, 1);
    tick();
    idle_inputs();
    tick();
    tick();
    if_flush = 1;
    tick();
    if_flush = 0;
    @(negedge clk);
    check("fl_mem_rsp", mem_rsp_valid, 1);
    tick();
    @(negedge clk);
    check("fl_no_rsp", if_rsp_valid, 0);
    check("fl_idle", busy, 0);
    wait_idle();
    check("fl_pulses", if_pulses, 0);
    if_pulses = 0;
    lsu_pulses = 0;
    if_req_valid = 1;
    if_req_addr = 32'h8000_0000;
    @(negedge clk);
    check("rs_grant", if_req_ready, 1);
    tick();
    idle_inputs();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("rs_mem_rsp", mem_rsp_valid, 1);
    check("rs_busy", busy, 0);
    check("rs_if_rdata", if_rsp_rdata, 0);
    check("rs_mem_addr", mem_req_addr, 0);
    check("rs_mem_valid", mem_req_valid, 0);
    tick();
    @(negedge clk);
    check("rs_no_rsp", {if_rsp_valid, lsu_rsp_valid}, 0);
    check("rs_busy_after", busy, 0);
    wait_idle();
    rsp_delay = 0;
    check("rs_pulses", if_pulses + lsu_pulses, 0);
    if_req_valid = 1;
    if_req_addr = 32'h8000_0400;
    if_flush = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("fg_no_grant", {if_req_ready, lsu_req_ready}, 0);
      tick();
    end
    if_flush = 0;
    @(negedge clk);
    check("fg_grant", if_req_ready, 1);
    tick();
    idle_inputs();
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
